// File: rtl/pm_scan_pkg.sv
// pm_scan_pkg
//   Shared constants and FSM state type for the power-rail mux scanner.
//   NUM_CH : number of mux channels (rails) scanned
//   MUX_W  : width of the mux select
package pm_scan_pkg;

  localparam int NUM_CH = 8;
  localparam int MUX_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } pm_scan_state_t;

endpackage

// File: rtl/pm_chan_debounce.sv
// pm_chan_debounce
//   Per-rail debounce. The status bit follows the synchronized sample only
//   after DEBOUNCE consecutive scan samples that disagree with it. One
//   sample that agrees with the status bit resets the run count.
// Ports
//   clk_50     in  1  system clock
//   reset      in  1  synchronous active-high reset
//   sample_en  in  1  one-cycle strobe; this rail is being sampled
//   d_s        in  1  synchronized rail-good sample
//   status_bit out 1  debounced rail-good (reset value 1)
module pm_chan_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk_50,
  input  logic reset,
  input  logic sample_en,
  input  logic d_s,
  output logic status_bit
);

  localparam int DCNT_W = $clog2(DEBOUNCE + 1);

  logic [DCNT_W-1:0] dcnt;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      dcnt       <= '0;
      status_bit <= 1'b1;
    end else if (sample_en) begin
      if (d_s == status_bit) begin
        dcnt <= '0;
      end else if (dcnt == DCNT_W'(DEBOUNCE - 1)) begin
        status_bit <= d_s;
        dcnt       <= '0;
      end else begin
        dcnt <= dcnt + DCNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/power_mux_scanner.sv
// power_mux_scanner
//   Steps the analog mux through all rails, holds each channel for a settle
//   time, samples the synchronized rail-good line, debounces it per rail,
//   keeps sticky per-rail faults and drives kill_sw for masked faults.
// Ports
//   clk_50      in  1  system clock, 50 MHz
//   reset       in  1  synchronous active-high reset
//   enable      in  1  level; 1 = scan continuously
//   data_in     in  1  async rail-good bit from the mux output
//   kill_mask   in  8  per-rail: fault on this rail asserts kill_sw
//   fault_clear in  1  one-cycle pulse; clears faults on rails now good
//   mux         out 3  current mux select
//   status      out 8  debounced rail-good vector
//   fault       out 8  sticky per-rail fault
//   kill_sw     out 1  1 = cut power (registered)
//   scan_done   out 1  one-cycle pulse after channel 7 is sampled
//
// state  | meaning
// IDLE   | not scanning; mux, status, fault held
// SETTLE | mux held, counting settle cycles
// SAMPLE | one cycle: debounce channel mux, advance mux
module power_mux_scanner
  import pm_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 50,
  parameter int DEBOUNCE      = 4
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              enable,
  input  logic              data_in,
  input  logic [NUM_CH-1:0] kill_mask,
  input  logic              fault_clear,
  output logic [MUX_W-1:0]  mux,
  output logic [NUM_CH-1:0] status,
  output logic [NUM_CH-1:0] fault,
  output logic              kill_sw,
  output logic              scan_done
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES);

  pm_scan_state_t    state;
  logic [CNT_W-1:0]  cnt;
  logic              d_m;
  logic              d_s;
  logic [NUM_CH-1:0] sample_en;

  // data_in is asynchronous; reset to "good" so no phantom fault follows reset.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      d_m <= 1'b1;
      d_s <= 1'b1;
    end else begin
      d_m <= data_in;
      d_s <= d_m;
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mux       <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SAMPLE: begin
          // The sampled channel always completes, so mux advances even
          // when enable has dropped.
          mux       <= mux + MUX_W'(1);
          scan_done <= (mux == MUX_W'(NUM_CH - 1));
          if (enable) begin
            cnt   <= '0;
            state <= SETTLE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    assign sample_en[i] = (state == SAMPLE) && (mux == MUX_W'(i));

    pm_chan_debounce #(
      .DEBOUNCE(DEBOUNCE)
    ) u_deb (
      .clk_50    (clk_50),
      .reset     (reset),
      .sample_en (sample_en[i]),
      .d_s       (d_s),
      .status_bit(status[i])
    );
  end

  // A rail that is still bad re-sets its fault, so set wins over clear.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      fault   <= '0;
      kill_sw <= 1'b0;
    end else begin
      fault   <= (fault & ~({NUM_CH{fault_clear}} & status)) | ~status;
      kill_sw <= |(fault & kill_mask);
    end
  end

endmodule
